// File: rtl/dcache_ctrl.sv
// Sequencing FSM for a direct-mapped, write-back, write-allocate data cache.
// Optional build macro DCACHE_UNCACHED_EN adds an uncached window at addr[31:29] == 3'b101.
// The address split must satisfy TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH + 2 == 32.
module dcache_ctrl #(
  parameter int TAG_WIDTH    = 20,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_en,
  input  logic [3:0]              cpu_wen,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic [INDEX_WIDTH-1:0]  line_index,
  output logic                    line_write_en,
  output logic                    line_valid_in,
  output logic                    line_dirty_in,
  output logic [TAG_WIDTH-1:0]    line_tag_in,
  output logic [OFFSET_WIDTH-1:0] line_offset,
  output logic [3:0]              line_byte_en,
  output logic [31:0]             line_data_in,
  input  logic                    line_valid_out,
  input  logic                    line_dirty_out,
  input  logic [TAG_WIDTH-1:0]    line_tag_out,
  input  logic [31:0]             line_data_out,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ready
);

  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REFILL
`ifdef DCACHE_UNCACHED_EN
    , UNCACHED
`endif
  } state_t;

  state_t                  state, state_next;
  logic [OFFSET_WIDTH-1:0] counter, counter_next;
  logic [29:0]             req_word_addr;
  logic [3:0]              req_wen;
  logic [31:0]             req_wdata;

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic                    hit;
  logic                    is_store;
  logic                    unused_addr_lsb;

  assign req_tag    = req_word_addr[29 -: TAG_WIDTH];
  assign req_index  = req_word_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_offset = req_word_addr[0 +: OFFSET_WIDTH];
  assign hit        = line_valid_out && (line_tag_out == req_tag);
  assign is_store   = |req_wen;
  // Byte address bits are always zero for word accesses and carry no information.
  assign unused_addr_lsb = ^cpu_addr[1:0];

  // NOTE: reset is sampled on the clock edge, and every register here is updated with <= so all
  // flops see the pre-edge values of each other regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      counter       <= '0;
      req_word_addr <= '0;
      req_wen       <= '0;
      req_wdata     <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (state == IDLE && cpu_en) begin
        req_word_addr <= cpu_addr[31:2];
        req_wen       <= cpu_wen;
        req_wdata     <= cpu_wdata;
      end
    end
  end

  // NOTE: every signal written below gets its default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    counter_next  = counter;
    cpu_rdata     = '0;
    cpu_ready     = 1'b0;
    line_index    = req_index;
    line_offset   = req_offset;
    line_write_en = 1'b0;
    line_valid_in = 1'b0;
    line_dirty_in = 1'b0;
    line_tag_in   = '0;
    line_byte_en  = '0;
    line_data_in  = '0;
    mem_valid     = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (state)
      IDLE: begin
        if (cpu_en) begin
`ifdef DCACHE_UNCACHED_EN
          state_next = (cpu_addr[31:29] == 3'b101) ? UNCACHED : COMPARE;
`else
          state_next = COMPARE;
`endif
        end
      end

      COMPARE: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          state_next = IDLE;
          if (is_store) begin
            line_write_en = 1'b1;
            line_byte_en  = req_wen;
            line_valid_in = 1'b1;
            line_dirty_in = 1'b1;
            line_tag_in   = req_tag;
            line_data_in  = req_wdata;
          end else begin
            cpu_rdata = line_data_out;
          end
        end else begin
          counter_next = '0;
          state_next   = line_dirty_out ? WRITEBACK : REFILL;
        end
      end

      // Victim address comes from the stored tag, not the requested one.
      WRITEBACK: begin
        line_offset = counter;
        mem_valid   = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {line_tag_out, req_index, counter, 2'b00};
        mem_wdata   = line_data_out;
        if (mem_ready) begin
          counter_next = counter + 1'b1;
          if (counter == LAST_WORD) state_next = REFILL;
        end
      end

      // The line only becomes valid with its last word, so an aborted fill never hits.
      REFILL: begin
        line_offset = counter;
        mem_valid   = 1'b1;
        mem_addr    = {req_tag, req_index, counter, 2'b00};
        if (mem_ready) begin
          line_write_en = 1'b1;
          line_byte_en  = 4'hF;
          line_data_in  = mem_rdata;
          line_tag_in   = req_tag;
          line_valid_in = (counter == LAST_WORD);
          counter_next  = counter + 1'b1;
          if (counter == LAST_WORD) state_next = COMPARE;
        end
      end

`ifdef DCACHE_UNCACHED_EN
      UNCACHED: begin
        mem_valid = 1'b1;
        mem_we    = is_store;
        mem_addr  = {req_word_addr, 2'b00};
        mem_wdata = req_wdata;
        if (mem_ready) begin
          cpu_rdata  = mem_rdata;
          cpu_ready  = 1'b1;
          state_next = IDLE;
        end
      end
`endif

      default: state_next = IDLE;
    endcase

    // Hold every strobe and bus quiet while reset is asserted so an aborted burst
    // cannot write a line or issue one more memory word.
    if (!rst) begin
      cpu_rdata     = '0;
      cpu_ready     = 1'b0;
      line_write_en = 1'b0;
      line_valid_in = 1'b0;
      line_dirty_in = 1'b0;
      line_tag_in   = '0;
      line_byte_en  = '0;
      line_data_in  = '0;
      mem_valid     = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a 64-line array model and a handshake-driven memory.
// Define DCACHE_UNCACHED_EN for both the RTL and this file to exercise the uncached window.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic [5:0]  line_index;
  logic        line_write_en, line_valid_in, line_dirty_in;
  logic [19:0] line_tag_in;
  logic [3:0]  line_offset;
  logic [3:0]  line_byte_en;
  logic [31:0] line_data_in;
  logic        line_valid_out, line_dirty_out;
  logic [19:0] line_tag_out;
  logic [31:0] line_data_out;
  logic        mem_valid, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.TAG_WIDTH(20), .INDEX_WIDTH(6), .OFFSET_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .line_index(line_index), .line_write_en(line_write_en), .line_valid_in(line_valid_in),
    .line_dirty_in(line_dirty_in), .line_tag_in(line_tag_in), .line_offset(line_offset),
    .line_byte_en(line_byte_en), .line_data_in(line_data_in),
    .line_valid_out(line_valid_out), .line_dirty_out(line_dirty_out),
    .line_tag_out(line_tag_out), .line_data_out(line_data_out),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Cache line array: combinational read of the selected line, byte-enabled write.
  logic        lv [64];
  logic        ld [64];
  logic [19:0] lt [64];
  logic [31:0] lm [64][16];

  assign line_valid_out = lv[line_index];
  assign line_dirty_out = lv[line_index] & ld[line_index];
  assign line_tag_out   = lt[line_index];
  assign line_data_out  = lm[line_index][line_offset];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        lv[i] <= 1'b0;
        ld[i] <= 1'b0;
        lt[i] <= '0;
        for (int w = 0; w < 16; w++) lm[i][w] <= '0;
      end
    end else if (line_write_en) begin
      lv[line_index] <= line_valid_in;
      ld[line_index] <= line_dirty_in;
      lt[line_index] <= line_tag_in;
      for (int b = 0; b < 4; b++)
        if (line_byte_en[b]) lm[line_index][line_offset][8*b +: 8] <= line_data_in[8*b +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [157:0] all_outputs();
    return {cpu_ready, cpu_rdata, mem_valid, mem_we, mem_addr, mem_wdata, line_write_en,
            line_byte_en, line_valid_in, line_dirty_in, line_tag_in, line_data_in};
  endfunction

  task automatic issue(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    @(negedge clk);
    cpu_en    = 1'b1;
    cpu_addr  = addr;
    cpu_wen   = wen;
    cpu_wdata = wdata;
  endtask

  // Drives n_words refill beats starting at a negedge in REFILL; optional stall before stall_word.
  task automatic refill_burst(input logic [31:0] base, input int stall_word, input int stall_len,
                              input int n_words);
    logic [31:0] a;
    for (int i = 0; i < n_words; i++) begin
      a = base + 32'(4 * i);
      if (i == stall_word) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          mem_ready = 1'b0;
          #1;
          checks++;
          if ({mem_valid, mem_we, line_write_en} !== 3'b100 || mem_addr !== a) begin
            errors++;
            $display("FAIL refill_stall w%0d s%0d: got valid/we/lwe=%b addr=%h, exp 100 addr=%h",
                     i, s, {mem_valid, mem_we, line_write_en}, mem_addr, a);
          end
        end
      end
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = mem_word(a);
      #1;
      checks++;
      if ({mem_valid, mem_we, line_write_en, line_byte_en, line_valid_in, line_dirty_in, cpu_ready}
          !== {3'b101, 4'hF, (i == 15), 2'b00}) begin
        errors++;
        $display("FAIL refill_ctl w%0d: got %b exp %b", i,
                 {mem_valid, mem_we, line_write_en, line_byte_en, line_valid_in, line_dirty_in, cpu_ready},
                 {3'b101, 4'hF, (i == 15), 2'b00});
      end
      checks++;
      if (mem_addr !== a || line_data_in !== mem_word(a) || line_tag_in !== base[31:12]
          || line_offset !== 4'(i)) begin
        errors++;
        $display("FAIL refill_data w%0d: got addr=%h data=%h tag=%h off=%0d exp addr=%h data=%h tag=%h off=%0d",
                 i, mem_addr, line_data_in, line_tag_in, line_offset, a, mem_word(a), base[31:12], i);
      end
    end
  endtask

  // Expects the negedge after the final refill beat: request completes in COMPARE.
  task automatic expect_load_done(input string name, input logic [31:0] exp_data);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== exp_data || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got ready=%b rdata=%h mem_valid=%b exp ready=1 rdata=%h mem_valid=0",
               name, cpu_ready, cpu_rdata, mem_valid, exp_data);
    end
    cpu_en = 1'b0;
  endtask

  task automatic expect_compare_miss(input string name, input logic [5:0] exp_index);
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_ready, mem_valid, line_write_en} !== 3'b000 || line_index !== exp_index) begin
      errors++;
      $display("FAIL %s: got ready/mvalid/lwe=%b index=%0d exp 000 index=%0d",
               name, {cpu_ready, mem_valid, line_write_en}, line_index, exp_index);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0", all_outputs());
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (all_outputs() !== '0 || line_index !== 6'd0 || line_offset !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle: got outs=%h index=%0d offset=%0d exp all 0",
               all_outputs(), line_index, line_offset);
    end
  endtask

  task automatic test_refill_load();
    issue(32'h0000_1040, 4'h0, 32'h0);
    #1;
    checks++;
    if ({cpu_ready, mem_valid} !== 2'b00) begin
      errors++;
      $display("FAIL accept_cycle: got ready/mvalid=%b exp 00", {cpu_ready, mem_valid});
    end
    expect_compare_miss("refill_compare", 6'd1);
    refill_burst(32'h0000_1040, -1, 0, 16);
    expect_load_done("refill_load_done", 32'hA5A5_1040);
    @(negedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_pulse: got %b exp 0", cpu_ready);
    end
  endtask

  task automatic test_hit_load();
    issue(32'h0000_1048, 4'h0, 32'h0);
    #1;
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL hit_load_early: got ready=%b exp 0", cpu_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_ready, mem_valid, line_write_en} !== 3'b100 || cpu_rdata !== 32'hA5A5_1048) begin
      errors++;
      $display("FAIL hit_load: got ready/mvalid/lwe=%b rdata=%h exp 100 rdata=a5a51048",
               {cpu_ready, mem_valid, line_write_en}, cpu_rdata);
    end
    cpu_en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_ready, mem_valid} !== 2'b00) begin
      errors++;
      $display("FAIL hit_load_after: got %b exp 00", {cpu_ready, mem_valid});
    end
  endtask

  task automatic test_hit_store();
    issue(32'h0000_1044, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_ready, mem_valid, line_write_en, line_byte_en, line_valid_in, line_dirty_in}
        !== {3'b101, 4'b0011, 2'b11}) begin
      errors++;
      $display("FAIL hit_store_ctl: got %b exp 101001111",
               {cpu_ready, mem_valid, line_write_en, line_byte_en, line_valid_in, line_dirty_in});
    end
    checks++;
    if (line_tag_in !== 20'h00001 || line_offset !== 4'd1 || line_data_in !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL hit_store_data: got tag=%h off=%0d data=%h exp tag=00001 off=1 data=deadbeef",
               line_tag_in, line_offset, line_data_in);
    end
    cpu_en = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (line_write_en !== 1'b0) begin
      errors++;
      $display("FAIL hit_store_once: got lwe=%b exp 0", line_write_en);
    end
  endtask

  task automatic test_writeback();
    logic [31:0] a, d;
    issue(32'h0010_1040, 4'h0, 32'h0);
    expect_compare_miss("wb_compare", 6'd1);
    for (int i = 0; i < 16; i++) begin
      a = 32'h0000_1040 + 32'(4 * i);
      d = (i == 1) ? 32'hA5A5_BEEF : mem_word(a);
      if (i == 3) begin
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          mem_ready = 1'b0;
          #1;
          checks++;
          if ({mem_valid, mem_we, line_write_en} !== 3'b110 || mem_addr !== a || mem_wdata !== d) begin
            errors++;
            $display("FAIL wb_stall s%0d: got %b addr=%h wdata=%h exp 110 addr=%h wdata=%h",
                     s, {mem_valid, mem_we, line_write_en}, mem_addr, mem_wdata, a, d);
          end
        end
      end
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({mem_valid, mem_we, line_write_en, cpu_ready} !== 4'b1100 || mem_addr !== a
          || mem_wdata !== d || line_offset !== 4'(i)) begin
        errors++;
        $display("FAIL wb_word w%0d: got %b addr=%h wdata=%h off=%0d exp 1100 addr=%h wdata=%h off=%0d",
                 i, {mem_valid, mem_we, line_write_en, cpu_ready}, mem_addr, mem_wdata, line_offset,
                 a, d, i);
      end
    end
    refill_burst(32'h0010_1040, -1, 0, 16);
    expect_load_done("wb_load_done", 32'hA5B5_1040);
  endtask

  task automatic test_back_to_back();
    issue(32'h0010_1048, 4'h0, 32'h0);
    @(negedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA5B5_1048) begin
      errors++;
      $display("FAIL b2b_first: got ready=%b rdata=%h exp 1 a5b51048", cpu_ready, cpu_rdata);
    end
    cpu_addr = 32'h0010_104C;
    @(negedge clk);
    #1;
    checks++;
    if ({cpu_ready, mem_valid} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_gap: got %b exp 00", {cpu_ready, mem_valid});
    end
    @(negedge clk);
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hA5B5_104C) begin
      errors++;
      $display("FAIL b2b_second: got ready=%b rdata=%h exp 1 a5b5104c", cpu_ready, cpu_rdata);
    end
    cpu_en = 1'b0;
  endtask

  task automatic test_stall_reset();
    issue(32'h0000_2080, 4'h0, 32'h0);
    expect_compare_miss("abort_compare", 6'd2);
    refill_burst(32'h0000_2080, 5, 5, 8);
    @(negedge clk);
    mem_ready = 1'b0;
    cpu_en    = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (all_outputs() !== '0 || line_index !== 6'd0) begin
      errors++;
      $display("FAIL abort_reset: got outs=%h index=%0d exp all 0", all_outputs(), line_index);
    end
    @(negedge clk);
    #1;
    checks++;
    if (mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got mem_valid=%b exp 0", mem_valid);
    end
    issue(32'h0000_2080, 4'h0, 32'h0);
    expect_compare_miss("abort_rerequest", 6'd2);
    refill_burst(32'h0000_2080, -1, 0, 16);
    expect_load_done("abort_reload_done", 32'hA5A5_2080);
  endtask

`ifdef DCACHE_UNCACHED_EN
  task automatic test_uncached();
    issue(32'hA000_0010, 4'h0, 32'h0);
    @(negedge clk);
    #1;
    checks++;
    if ({mem_valid, mem_we, line_write_en, cpu_ready} !== 4'b1000 || mem_addr !== 32'hA000_0010) begin
      errors++;
      $display("FAIL unc_load_req: got %b addr=%h exp 1000 addr=a0000010",
               {mem_valid, mem_we, line_write_en, cpu_ready}, mem_addr);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = mem_word(32'hA000_0010);
    #1;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h05A5_0010 || line_write_en !== 1'b0) begin
      errors++;
      $display("FAIL unc_load_done: got ready=%b rdata=%h lwe=%b exp 1 05a50010 0",
               cpu_ready, cpu_rdata, line_write_en);
    end
    cpu_en = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    issue(32'hA000_0020, 4'hF, 32'h1234_5678);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_valid, mem_we, line_write_en, cpu_ready} !== 4'b1101 || mem_addr !== 32'hA000_0020
        || mem_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL unc_store: got %b addr=%h wdata=%h exp 1101 a0000020 12345678",
               {mem_valid, mem_we, line_write_en, cpu_ready}, mem_addr, mem_wdata);
    end
    cpu_en = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
  endtask
`else
  task automatic test_uncached();
    issue(32'hA000_0010, 4'h0, 32'h0);
    expect_compare_miss("cached_window_compare", 6'd0);
    refill_burst(32'hA000_0000, -1, 0, 16);
    expect_load_done("cached_window_done", 32'h05A5_0010);
  endtask
`endif

  initial begin
    test_reset();
    test_refill_load();
    test_hit_load();
    test_hit_store();
    test_writeback();
    test_back_to_back();
    test_stall_reset();
    test_uncached();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
